// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder using one full-adder slice and a carry flop.
// Optional signed overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb;
  logic c;
  logic [CW-1:0] cnt;
  logic fs, fc, last;
  assign fs = ra[0] ^ rb[0] ^ c;
  assign fc = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      ra       <= '0;
      rb       <= '0;
      c        <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          c     <= carryin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          sum <= {fs, sum[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          c   <= fc;
          if (last) begin
            carryout <= fc;
            done     <= 1'b1;
            state    <= DONE;
          end else
            cnt <= cnt + 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SERIAL_ADDER_OVERFLOW_EN
  // carry into the MSB differs from carry out of it exactly on signed overflow
  logic ovf;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == SHIFT && last) ovf <= c ^ fc;
  assign overflow = ovf;
`else
  assign overflow = 1'b0;
`endif
endmodule
